// File: rtl/apb_sys_param.sv
// apb_sys_param: command-driven APB master FSM plus an internal word-addressed register-bank slave.
// Byte-lane strobes (cmd_strb/PSTRB) exist only when APB_PSTRB_EN is defined.
module apb_sys_param #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);
  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_strb;
  logic              r_psel;
  logic              r_penable;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] r_bank [DEPTH];

  logic [NB-1:0]     w_cmd_strb;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_pready;
  logic [DATA_W-1:0] w_prdata;

`ifdef APB_PSTRB_EN
  assign w_cmd_strb = cmd_strb;
  assign PSTRB      = (r_psel && r_write) ? r_strb : '0;
`else
  assign w_cmd_strb = '1;
`endif

  // No wrap-around: any index at or beyond DEPTH is rejected with PSLVERR.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_pready   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_prdata   = ((r_state == S_ACCESS) && !r_write && w_in_range) ? r_bank[w_idx] : '0;

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_write;
  assign PADDR     = r_addr;
  assign PWDATA    = r_wdata;
  assign PRDATA    = w_prdata;
  assign PREADY    = w_pready;
  assign PSLVERR   = w_pready && !w_in_range;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_write     <= cmd_write;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_strb      <= w_cmd_strb;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_cnt     <= WS_L;
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Completion edge: commit write, capture response, re-open the command port.
            if (r_write && w_in_range) begin
              for (int b = 0; b < NB; b++)
                if (r_strb[b]) r_bank[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_in_range;
            r_rsp_rdata <= w_prdata;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_sys_param.sv
// Bench for apb_sys_param: scoreboard of expected responses plus directed timing checks.
// A second instance with WAIT_STATES=3 exercises the wait-state path.
module tb_apb_sys_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]  cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb  = '0;
  logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic [7:0]  paddr;

  logic        b_cmd_valid = 1'b0, b_cmd_write = 1'b0;
  logic [7:0]  b_cmd_addr  = '0;
  logic [31:0] b_cmd_wdata = '0;
  logic [3:0]  b_cmd_strb  = 4'hF;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
  logic [31:0] b_rsp_rdata, b_pwdata, b_prdata;
  logic [7:0]  b_paddr;
`ifdef APB_PSTRB_EN
  logic [3:0]  pstrb, b_pstrb;
`endif

  apb_sys_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) dut (
    .PCLK(clk), .PRESET(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef APB_PSTRB_EN
    .cmd_strb(cmd_strb), .PSTRB(pstrb),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr));

  apb_sys_param #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_STATES(3)) dut_ws (
    .PCLK(clk), .PRESET(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
`ifdef APB_PSTRB_EN
    .cmd_strb(b_cmd_strb), .PSTRB(b_pstrb),
`endif
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr));

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic ee, input logic [31:0] er);
    exp_t e;
    e.err   = ee;
    e.rdata = er;
    sb_q.push_back(e);
  endtask

  function automatic logic [127:0] outs_main();
    return 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite,
                 paddr, pwdata, prdata, pready, pslverr});
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 128'(rsp_valid), 128'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        check("rsp_err", 128'(rsp_err), 128'(e.err));
      end
    end
  end

  // Issues one command to the main instance and checks PREADY/rsp_valid cycle positions.
  task automatic run_cmd(input string tag, input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ee, input logic [31:0] er);
    int n, pr, rv;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({tag, "_accept_timeout"}, 128'(cmd_ready), 128'(1));
    push_exp(ee, er);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pr = -1; rv = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pready === 1'b1 && pr < 0) pr = c;
      if (rsp_valid === 1'b1) begin rv = c; break; end
    end
    check({tag, "_pready_cycle"}, 128'(pr), 128'(2));
    check({tag, "_rsp_cycle"}, 128'(rv), 128'(3));
  endtask

  initial begin
    int  n, pen, prc, pr, rv;
    logic [31:0] rd_ws;
    time t_prev, t_now;

    #12;
    check("reset_outputs", outs_main(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 128'(cmd_ready), 128'(1));

    run_cmd("wr3", 1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    run_cmd("rd3", 1'b0, 8'd3, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);

    run_cmd("wr15", 1'b1, 8'd15, 32'hA5A50F0F, 4'hF, 1'b0, 32'h0);
    run_cmd("wr16", 1'b1, 8'd16, 32'h12345678, 4'hF, 1'b1, 32'h0);
    run_cmd("rd15", 1'b0, 8'd15, 32'h0, 4'hF, 1'b0, 32'hA5A50F0F);
    run_cmd("rd16", 1'b0, 8'd16, 32'h0, 4'hF, 1'b1, 32'h0);

    // Back-to-back: cmd_valid held high across four writes.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_strb = 4'hF;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      cmd_addr  = 8'(k);
      cmd_wdata = 32'h1111_0000 + 32'(k * 32'h0101);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("b2b_accept_timeout", 128'(cmd_ready), 128'(1));
      push_exp(1'b0, 32'h0);
      @(posedge clk);
      t_now = $time;
      if (k > 0) check("b2b_interval", 128'((t_now - t_prev) / 10), 128'(3));
      t_prev = t_now;
      #1;
    end
    cmd_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("b2b_drain", 128'(sb_q.size()), 128'(0));
    for (int k = 0; k < 4; k++)
      run_cmd("b2b_rd", 1'b0, 8'(k), 32'h0, 4'hF, 1'b0, 32'h1111_0000 + 32'(k * 32'h0101));

`ifdef APB_PSTRB_EN
    run_cmd("st_full", 1'b1, 8'd5, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    run_cmd("st_lane2", 1'b1, 8'd5, 32'h00AA0000, 4'b0100, 1'b0, 32'h0);
    run_cmd("st_rd", 1'b0, 8'd5, 32'h0, 4'hF, 1'b0, 32'hFFAAFFFF);
    run_cmd("st_none", 1'b1, 8'd5, 32'h00000000, 4'b0000, 1'b0, 32'h0);
    run_cmd("st_rd2", 1'b0, 8'd5, 32'h0, 4'hF, 1'b0, 32'hFFAAFFFF);
`endif

    // Wait-state instance: read addr 0.
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 8'd0;
    n = 0;
    while (b_cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ws_accept_timeout", 128'(b_cmd_ready), 128'(1));
    @(posedge clk);
    #1 b_cmd_valid = 1'b0;
    pen = 0; prc = 0; pr = -1; rv = -1; rd_ws = 32'hFFFF_FFFF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (b_penable === 1'b1) pen++;
      if (b_pready === 1'b1) begin prc++; pr = c; end
      if (b_rsp_valid === 1'b1) begin rv = c; rd_ws = b_rsp_rdata; end
    end
    check("ws_penable_cycles", 128'(pen), 128'(4));
    check("ws_pready_count", 128'(prc), 128'(1));
    check("ws_pready_cycle", 128'(pr), 128'(5));
    check("ws_rsp_cycle", 128'(rv), 128'(6));
    check("ws_rdata", 128'(rd_ws), 128'(0));

    // Reset during ACCESS of a write to addr 2.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd2; cmd_wdata = 32'hCAFE_F00D; cmd_strb = 4'hF;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_access", 128'(penable), 128'(1));
    rst = 1'b1;
    #1 check("rst_outputs_now", outs_main(), 128'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_outputs_held", outs_main(), 128'(0));
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_rsp", 128'(rsp_valid), 128'(0));
    end
    run_cmd("rd2_after_rst", 1'b0, 8'd2, 32'h0, 4'hF, 1'b0, 32'h0);

    repeat (4) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
